rv32i_encoder: RTL and testbench
================================

RV32I_ENCODER -- requirements
Module: rv32i_encoder

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16: width of the output-handshake counter.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1: input field bundle valid.
REQ-005 SHALL have port in_ready, output, 1: encoder can accept a bundle.
REQ-006 SHALL have ports in_opcode (input, 7), in_funct3 (input, 3), in_funct7 (input, 7): instruction opcode and function fields.
REQ-007 SHALL have ports in_rd, in_rs1, in_rs2 (input, 5 each): register indices.
REQ-008 SHALL have port in_imm, input, 32: unshifted sign-extended immediate, as produced by field decode.
REQ-009 SHALL have port out_valid, output, 1: encoded word valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts word.
REQ-011 SHALL have port out_inst, output, 32: encoded RV32I instruction word.
REQ-012 SHALL have port out_error, output, 1: bundle not encodable exactly; qualified by out_valid.
REQ-013 SHALL have port count_encoded, output, COUNT_WIDTH: number of completed output handshakes.

Function
REQ-014 SHALL accept a bundle when in_valid and in_ready are both high, and complete a word when out_valid and out_ready are both high.
REQ-015 SHALL present the accepted bundle's word with out_valid high no earlier than the cycle after acceptance (1-cycle latency); ordering SHALL be preserved.
REQ-016 SHALL buffer up to 2 words; in_ready SHALL be registered and high exactly when fewer than 2 words are held.
REQ-017 SHALL sustain 1 word/cycle while out_ready is held high.
REQ-018 SHALL handle a simultaneous accept and complete while full or empty without loss or duplication.
REQ-019 SHALL encode opcode 0x33 (R-type) as {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-020 SHALL encode opcodes 0x13, 0x03, 0x67 and 0x73 (I-type) as {imm[11:0], rs1, funct3, rd, opcode}.
REQ-021 SHALL encode opcode 0x13 with funct3 1 or 5 (shifts) as {funct7, imm[4:0], rs1, funct3, rd, opcode}.
REQ-022 SHALL encode opcode 0x23 (S-type) as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-023 SHALL encode opcode 0x63 (B-type) as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-024 SHALL encode opcodes 0x37 and 0x17 (U-type) as {imm[31:12], rd, opcode}.
REQ-025 SHALL encode opcode 0x6F (J-type) as {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-026 SHALL, for any other opcode, output out_inst = 0x00000000 with out_error = 1, regardless of configuration.
REQ-027 SHALL increment count_encoded by 1 per output handshake, wrapping from all-ones to 0.

Reset
REQ-028 SHALL, while rst is high, force out_valid = 0, out_inst = 0, out_error = 0, count_encoded = 0 and in_ready = 0.
REQ-029 SHALL raise in_ready on the first clock edge after rst deasserts.
REQ-030 SHALL discard all buffered words when rst asserts mid-operation; no word is emitted after reset until a new bundle is accepted.

Configuration
REQ-031 SHALL, with macro RV32I_ENCODER_CHECK_EN defined, additionally set out_error for each of these cases:
- I/S immediates not sign-extended from bit 11.
- B immediates not sign-extended from bit 12, or imm[0] != 0.
- J immediates not sign-extended from bit 20, or imm[0] != 0.
- U immediates with imm[11:0] != 0.
- Shifts with imm[31:5] != 0, or funct7 outside {0x00, 0x20}.
- funct7 = 0x20 with any shift funct3 other than 5.
- R-type with funct7 outside {0x00, 0x20}.
In every case the word SHALL still be encoded per REQ-019..REQ-025.
REQ-032 SHALL, without RV32I_ENCODER_CHECK_EN, set out_error only per REQ-026, and the check logic SHALL be absent.

Verification
REQ-033 SHALL cover: ADD opcode 0x33, funct3 0, funct7 0, rd 3, rs1 1, rs2 2 -> out_inst 0x002081B3 one cycle after accept, out_error 0.
REQ-034 SHALL cover: BEQ opcode 0x63, funct3 0, rs1 1, rs2 2, imm 0xFFFFFFFC -> out_inst 0xFE208EE3, out_error 0.
REQ-035 SHALL cover: out_ready low, 3 bundles offered back-to-back -> exactly 2 accepted, in_ready 0; out_ready high -> words in order, in_ready 1, count_encoded 2.
REQ-036 SHALL cover: ADDI opcode 0x13, funct3 0, rd 0, rs1 0, imm 0x00000800 -> out_inst 0x80000013; out_error 1 with RV32I_ENCODER_CHECK_EN, 0 without.
REQ-037 SHALL cover: opcode 0x7F -> out_inst 0x00000000, out_error 1 in both configurations.
REQ-038 SHALL cover: rst pulsed with 2 words buffered -> out_valid 0 and count_encoded 0 immediately, in_ready 1 on the first edge after release.

Source files
------------

// File: rtl/rv32i_encoder.sv
// rv32i_encoder: packs decoded RV32I instruction fields back into a 32-bit
// instruction word. A two-entry buffer sits between the valid/ready input
// and output handshakes, and the block counts completed output words.
// Optional macro RV32I_ENCODER_CHECK_EN adds immediate/funct7 legality checks
// that raise out_error. The word is still encoded when a check fails.
module rv32i_encoder #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [6:0]             in_opcode,
  input  logic [2:0]             in_funct3,
  input  logic [6:0]             in_funct7,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [31:0]            in_imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_inst,
  output logic                   out_error,
  output logic [COUNT_WIDTH-1:0] count_encoded
);

  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  logic        is_shift;
  logic [31:0] enc_inst;
  logic        enc_error;
  logic        check_error;

  logic [32:0]            slot [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             count;
  logic [1:0]             count_next;
  logic                   ready_q;
  logic [COUNT_WIDTH-1:0] done_count;
  logic                   accept;
  logic                   complete;

  assign is_shift = (in_funct3 == 3'd1) || (in_funct3 == 3'd5);

  // Field packing per instruction format; unknown opcodes yield a zero word with error
  always_comb begin
    enc_inst  = 32'h0000_0000;
    enc_error = 1'b0;
    case (in_opcode)
      OP_REG:
        enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      OP_IMM:
        if (is_shift) enc_inst = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
        else          enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      OP_LOAD, OP_JALR, OP_SYSTEM:
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      OP_STORE:
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      OP_BRANCH:
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
      OP_LUI, OP_AUIPC:
        enc_inst = {in_imm[31:12], in_rd, in_opcode};
      OP_JAL:
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      default: begin
        enc_inst  = 32'h0000_0000;
        enc_error = 1'b1;
      end
    endcase
  end

`ifdef RV32I_ENCODER_CHECK_EN
  logic sext12_ok;
  logic sext13_ok;
  logic sext21_ok;
  logic f7_std;

  assign sext12_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign sext13_ok = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign sext21_ok = (&in_imm[31:20]) | ~(|in_imm[31:20]);
  assign f7_std    = (in_funct7 == 7'h00) || (in_funct7 == 7'h20);

  // Flag fields that the chosen format cannot represent exactly
  always_comb begin
    check_error = 1'b0;
    case (in_opcode)
      OP_REG:
        check_error = !f7_std;
      OP_IMM:
        if (is_shift) check_error = (|in_imm[31:5]) || !f7_std ||
                                    ((in_funct7 == 7'h20) && (in_funct3 != 3'd5));
        else          check_error = !sext12_ok;
      OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE:
        check_error = !sext12_ok;
      OP_BRANCH:
        check_error = !sext13_ok || in_imm[0];
      OP_LUI, OP_AUIPC:
        check_error = |in_imm[11:0];
      OP_JAL:
        check_error = !sext21_ok || in_imm[0];
      default:
        check_error = 1'b0;
    endcase
  end
`else
  logic unused_imm_lsb;

  assign unused_imm_lsb = in_imm[0];
  assign check_error    = 1'b0;
`endif

  assign accept    = in_valid && ready_q;
  assign out_valid = (count != 2'd0);
  assign complete  = out_valid && out_ready;
  assign in_ready  = ready_q;

  // Occupancy after this cycle's accept and completion
  always_comb begin
    count_next = count + 2'(accept) - 2'(complete);
  end

  // Two-slot buffer, registered ready flag and handshake counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot[0]    <= '0;
      slot[1]    <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      ready_q    <= 1'b0;
      done_count <= '0;
    end else begin
      if (accept) begin
        slot[wr_ptr] <= {enc_error | check_error, enc_inst};
        wr_ptr       <= ~wr_ptr;
      end
      if (complete) begin
        rd_ptr     <= ~rd_ptr;
        done_count <= done_count + 1'b1;
      end
      count   <= count_next;
      ready_q <= (count_next != 2'd2);
    end
  end

  assign out_inst      = out_valid ? slot[rd_ptr][31:0] : 32'h0000_0000;
  assign out_error     = out_valid ? slot[rd_ptr][32]   : 1'b0;
  assign count_encoded = done_count;

endmodule

// File: tb/tb_rv32i_encoder.sv
// tb_rv32i_encoder: directed bench for rv32i_encoder. A queue-based model
// predicts words, errors, ready and count; literal expectations pin it.
module tb_rv32i_encoder;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [6:0]    in_opcode = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [4:0]    in_rd = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [31:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_inst;
  logic          out_error;
  logic [CW-1:0] count_encoded;

  int checks = 0;
  int errors = 0;
  bit live   = 1'b0;
`ifdef RV32I_ENCODER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic [32:0]   exp_q[$];
  logic [CW-1:0] m_count;
  logic          m_ready;

  rv32i_encoder #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_error(out_error), .count_encoded(count_encoded)
  );

  always #5 clk = ~clk;

  // Reference encoding: field values placed by arithmetic shifts, legality by numeric ranges
  function automatic logic [32:0] model_word(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [31:0] imm);
    logic [31:0] w;
    logic        bad;
    logic        e;
    int          s;
    logic [31:0] base;
    s    = $signed(imm);
    base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    bad  = 1'b0;
    e    = 1'b0;
    case (op)
      7'h33: begin
        w = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
        bad = !(f7 == 7'd0 || f7 == 7'd32);
      end
      7'h13, 7'h03, 7'h67, 7'h73: begin
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          w = (32'(f7) << 25) | ((imm % 32) << 20) | base | (32'(rd) << 7);
          bad = (imm >= 32) || !(f7 == 7'd0 || f7 == 7'd32) || (f7 == 7'd32 && f3 != 3'd5);
        end else begin
          w = ((imm % 4096) << 20) | base | (32'(rd) << 7);
          bad = (s < -2048) || (s > 2047);
        end
      end
      7'h23: begin
        w = (((imm / 32) % 128) << 25) | (32'(rs2) << 20) | base | ((imm % 32) << 7);
        bad = (s < -2048) || (s > 2047);
      end
      7'h63: begin
        w = (((imm / 4096) % 2) << 31) | (((imm / 32) % 64) << 25) | (32'(rs2) << 20) | base |
            (((imm / 2) % 16) << 8) | (((imm / 2048) % 2) << 7);
        bad = (s < -4096) || (s > 4095) || (imm % 2 != 0);
      end
      7'h37, 7'h17: begin
        w = (imm - (imm % 4096)) | (32'(rd) << 7) | 32'(op);
        bad = (imm % 4096 != 0);
      end
      7'h6F: begin
        w = (((imm / 1048576) % 2) << 31) | (((imm / 2) % 1024) << 21) |
            (((imm / 2048) % 2) << 20) | (((imm / 4096) % 256) << 12) |
            (32'(rd) << 7) | 32'(op);
        bad = (s < -1048576) || (s > 1048575) || (imm % 2 != 0);
      end
      default: begin
        w = 32'd0;
        e = 1'b1;
      end
    endcase
    return {e | (bad & CHK), w};
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model state: queue of pending words, handshake counter and registered ready
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_count <= '0;
      m_ready <= 1'b0;
    end else begin
      if (exp_q.size() != 0 && out_ready) begin
        void'(exp_q.pop_front());
        m_count <= m_count + 1'b1;
      end
      if (in_valid && m_ready)
        exp_q.push_back(model_word(in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm));
      m_ready <= (exp_q.size() < 2);
    end
  end

  // Compare DUT against the model every falling edge once reset has been seen
  always @(negedge clk) begin
    if (live) begin
      check_output("in_ready", 32'(in_ready), 32'(m_ready));
      check_output("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check_output("count_encoded", 32'(count_encoded), 32'(m_count));
      if (exp_q.size() != 0) begin
        check_output("out_inst", out_inst, exp_q[0][31:0]);
        check_output("out_error", 32'(out_error), 32'(exp_q[0][32]));
      end
      if (rst) begin
        check_output("rst_out_inst", out_inst, 32'd0);
        check_output("rst_out_error", 32'(out_error), 32'd0);
      end
    end
  end

  // Offer one bundle for one cycle; leaves the bench just after the clock edge
  task automatic apply_stimulus(input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm);
    in_valid  = 1'b1;
    in_opcode = op;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 live = 1'b1;
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_in_ready", 32'(in_ready), 32'd0);
    check_output("reset_count", 32'(count_encoded), 32'd0);
    check_output("reset_out_inst", out_inst, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("ready_after_release", 32'(in_ready), 32'd1);

    // Literal anchors with a one-cycle latency observation
    out_ready = 1'b1;
    apply_stimulus(7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0);
    check_output("add_valid", 32'(out_valid), 32'd1);
    check_output("add_inst", out_inst, 32'h002081B3);
    check_output("add_error", 32'(out_error), 32'd0);
    apply_stimulus(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    check_output("beq_inst", out_inst, 32'hFE208EE3);
    check_output("beq_error", 32'(out_error), 32'd0);
    apply_stimulus(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h00000800);
    check_output("addi_inst", out_inst, 32'h80000013);
    check_output("addi_error", 32'(out_error), 32'(CHK));
    apply_stimulus(7'h7F, 3'd0, 7'h00, 5'd5, 5'd6, 5'd7, 32'h12345678);
    check_output("bad_op_inst", out_inst, 32'h00000000);
    check_output("bad_op_error", 32'(out_error), 32'd1);

    // Back-to-back mix of formats, legal and illegal fields
    apply_stimulus(7'h33, 3'd0, 7'h20, 5'd5, 5'd6, 5'd7, 32'd0);
    apply_stimulus(7'h33, 3'd1, 7'h01, 5'd8, 5'd9, 5'd10, 32'd0);
    apply_stimulus(7'h23, 3'd2, 7'h00, 5'd0, 5'd2, 5'd8, 32'hFFFFFFF4);
    apply_stimulus(7'h03, 3'd2, 7'h00, 5'd11, 5'd2, 5'd0, 32'd2047);
    apply_stimulus(7'h37, 3'd0, 7'h00, 5'd12, 5'd0, 5'd0, 32'hABCDE000);
    apply_stimulus(7'h17, 3'd0, 7'h00, 5'd13, 5'd0, 5'd0, 32'h12345001);
    apply_stimulus(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFF00000);
    apply_stimulus(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h000FFFFE);
    apply_stimulus(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h00100000);
    apply_stimulus(7'h67, 3'd0, 7'h00, 5'd0, 5'd1, 5'd0, 32'hFFFFF800);
    apply_stimulus(7'h73, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd1);
    apply_stimulus(7'h13, 3'd1, 7'h00, 5'd4, 5'd4, 5'd0, 32'd31);
    apply_stimulus(7'h13, 3'd5, 7'h20, 5'd4, 5'd4, 5'd0, 32'd3);
    apply_stimulus(7'h13, 3'd1, 7'h20, 5'd4, 5'd4, 5'd0, 32'd3);
    apply_stimulus(7'h13, 3'd5, 7'h00, 5'd4, 5'd4, 5'd0, 32'd33);
    apply_stimulus(7'h63, 3'd1, 7'h00, 5'd0, 5'd3, 5'd4, 32'd4094);
    apply_stimulus(7'h63, 3'd1, 7'h00, 5'd0, 5'd3, 5'd4, 32'd7);
    apply_stimulus(7'h63, 3'd4, 7'h00, 5'd0, 5'd3, 5'd4, 32'hFFFFF000);
    apply_stimulus(7'h23, 3'd0, 7'h00, 5'd0, 5'd3, 5'd4, 32'd2048);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: full buffer refuses a third bundle, then drains in order
    pulse_reset();
    out_ready = 1'b0;
    apply_stimulus(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0);
    apply_stimulus(7'h13, 3'd0, 7'h00, 5'd4, 5'd5, 5'd0, 32'd100);
    apply_stimulus(7'h37, 3'd0, 7'h00, 5'd6, 5'd0, 5'd0, 32'h55555000);
    check_output("full_in_ready", 32'(in_ready), 32'd0);
    check_output("full_head_inst", out_inst, 32'h003100B3);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("drain_count", 32'(count_encoded), 32'd2);
    check_output("drain_in_ready", 32'(in_ready), 32'd1);
    check_output("drain_out_valid", 32'(out_valid), 32'd0);

    // Reset while two words are buffered
    out_ready = 1'b0;
    apply_stimulus(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0);
    apply_stimulus(7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0);
    #2 rst = 1'b1;
    #1;
    check_output("midrst_out_valid", 32'(out_valid), 32'd0);
    check_output("midrst_count", 32'(count_encoded), 32'd0);
    check_output("midrst_in_ready", 32'(in_ready), 32'd0);
    check_output("midrst_out_inst", out_inst, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check_output("release_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check_output("release_in_ready_high", 32'(in_ready), 32'd1);
    check_output("release_out_valid", 32'(out_valid), 32'd0);

    // Sustained stream with irregular backpressure; counter wraps past all-ones
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 3 != 0);
      apply_stimulus(7'h13, 3'(i % 8), 7'h00, 5'(i), 5'(i + 1), 5'd0, 32'(i * 37));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++)
      apply_stimulus(7'h33, 3'd0, 7'h00, 5'(i), 5'(i), 5'(i), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
